axi4_cmd_master: RTL and testbench
==================================

# axi4_cmd_master

Single-outstanding AXI4 initiator that turns simple command-channel requests into single-beat AXI4 reads and writes. It is the master-side counterpart of the system's register-style AXI4 slaves (sys control, coreinfo, msgqueue bridges). It sits between a debug or test command source (UART monitor, bench driver) and an interconnect master port, and returns read data and response codes on a response channel.

## Interface
- AXI4_ADDRESS_WIDTH, 32, address width of master port and cmd_addr
- AXI4_DATA_WIDTH, 32, data width; fixed at 32 in this revision
- AXI4_ID_WIDTH, 4, ID width of master port
- MASTER_ID, 0, value driven on AWID/ARID
- TIMEOUT_CYCLES, 1024, abort threshold; used only with the timeout macro
- clk_i  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address; bits [1:0] ignored, forced 0 on AxADDR
- cmd_wdata  in  32  write data
- cmd_wstrb  in  4  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  32  read data; 0 for writes
- rsp_resp  out  2  RRESP/BRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by timeout
- master  axi4_if.master  AXI4 initiator port

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/wdata/wstrb/write and go to RD_ADDR or WR_ADDR_DATA.
- RD_ADDR: ARVALID=1. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP and go to RSP. RLAST is not checked.
- WR_ADDR_DATA: AWVALID and WVALID asserted together. Each drops independently after its own handshake. Go to WR_RESP once both have completed; either order, or the same cycle.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, set rsp_rdata=0, go to RSP.
- RSP: rsp_valid=1, outputs held stable. On rsp_ready, go to IDLE.
- Fixed AXI fields: AxLEN=0, AxSIZE=3'b010, AxBURST=2'b01, AxPROT/AxCACHE/AxLOCK/AxQOS/AxREGION=0, WLAST=1.
- RREADY and BREADY are also 1 in IDLE and RSP. Any stray beat arriving there is discarded.
- BID/RID are not checked.

## Timing
- Reset values: cmd_ready=0 during reset, then 1 in the first IDLE cycle. All AXI VALIDs 0, RREADY=0, BREADY=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0.
- ARVALID/AWVALID first assert the cycle after cmd acceptance.
- Zero-wait slave:
  - read: accept at T, ARVALID at T+1, RVALID at T+2, rsp_valid at T+3
  - write: AW/W at T+1, B at T+2, rsp_valid at T+3
- rsp_ready high in the first RSP cycle gives IDLE next cycle. Minimum command spacing is 4 cycles.
- VALIDs never drop before their handshake except on timeout or reset.
- Reset mid-operation: next cycle IDLE, all VALIDs and rsp_valid low, latched command discarded.

## Configuration
- AXI4_CMD_MASTER_TIMEOUT_EN defined:
  - A counter clears on command acceptance and increments every non-IDLE, non-RSP cycle.
  - When it reaches TIMEOUT_CYCLES, all VALIDs drop and the state goes to RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
  - A response arriving in the same cycle as the timeout wins: normal response, no timeout.
- Undefined: no counter; the master waits indefinitely and rsp_timeout is tied 0.

## Structure
- Package axi4_cmd_master_pkg holds:
  - state enum
  - AXI constants: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, SIZE_4B
- Single module; the timeout counter stays inline, so no sub-module.

## Test plan
- Write 0x8000_0000 data 0x0000_0005 wstrb 0xF → one AW/W with WLAST=1, AWLEN=0; rsp_resp=0, rsp_rdata=0 at T+3.
- Read 0x2000_0010, slave returns 0xDEAD_BEEF RRESP=0 after 5 wait cycles → rsp_rdata=0xDEAD_BEEF, exactly one ARVALID handshake.
- WREADY 3 cycles before AWREADY, then the reverse order → single B accepted, no duplicate W beat.
- Slave returns DECERR on read → rsp_resp=2'b11; rsp_ready low for 10 cycles → rsp_valid and data stable, cmd_ready=0.
- TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never asserts ARREADY → rsp_valid at cycle 17 after accept, rsp_resp=2'b10, rsp_timeout=1.
- rst_n low during WR_RESP → next cycle all VALIDs 0, rsp_valid 0; following command completes normally.

Source files
------------

// File: rtl/axi4_cmd_master_pkg.sv
// Shared types and AXI4 field constants for the single-outstanding command master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4_cmd_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP,
        RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

endpackage

// File: rtl/axi4_cmd_master_if.sv
// AXI4 master port bundle (AW, W, B, AR, R channels) with master/slave views.
// Latency: none, wires only.
// Backpressure: standard AXI4 VALID/READY per channel.
interface axi4_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [3:0]          arregion;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 initiator: one cmd beat -> one single-beat AXI read or write -> one rsp beat.
// Latency: accept at T, AR/AW+W at T+1, rsp_valid at T+3 against a zero-wait slave.
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready; AXI VALIDs held until handshake.
// Ports: clk_i/rst_n (sync, active-low); cmd_* request channel; rsp_* response channel; master = AXI4 port.
// Optional: define AXI4_CMD_MASTER_TIMEOUT_EN to abort after TIMEOUT_CYCLES busy cycles (rsp_resp=SLVERR, rsp_timeout=1).
module axi4_cmd_master
    import axi4_cmd_master_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MASTER_ID          = 0,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]  cmd_addr,
    input  logic [AXI4_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI4_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [AXI4_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           rsp_timeout,
    axi4_cmd_master_if.master              master
);

    state_e                          state_q, state_d;
    logic                            aw_done_q, w_done_q;
    logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
    logic [AXI4_DATA_WIDTH-1:0]      wdata_q;
    logic [AXI4_DATA_WIDTH/8-1:0]    wstrb_q;
    logic [AXI4_DATA_WIDTH-1:0]      rdata_q;
    logic [1:0]                      resp_q;

`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_q;
    logic             busy;
    logic             rsp_hit;
    logic             tmo_fire;
`endif

    // Fixed single-beat, 4-byte, INCR attributes; low address bits are dropped at latch time.
    assign master.awid     = AXI4_ID_WIDTH'(MASTER_ID);
    assign master.awaddr   = addr_q;
    assign master.awlen    = 8'd0;
    assign master.awsize   = SIZE_4B;
    assign master.awburst  = BURST_INCR;
    assign master.awlock   = 1'b0;
    assign master.awcache  = 4'd0;
    assign master.awprot   = 3'd0;
    assign master.awqos    = 4'd0;
    assign master.awregion = 4'd0;
    assign master.wdata    = wdata_q;
    assign master.wstrb    = wstrb_q;
    assign master.wlast    = 1'b1;
    assign master.arid     = AXI4_ID_WIDTH'(MASTER_ID);
    assign master.araddr   = addr_q;
    assign master.arlen    = 8'd0;
    assign master.arsize   = SIZE_4B;
    assign master.arburst  = BURST_INCR;
    assign master.arlock   = 1'b0;
    assign master.arcache  = 4'd0;
    assign master.arprot   = 3'd0;
    assign master.arqos    = 4'd0;
    assign master.arregion = 4'd0;

    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    // IDs, RLAST and the ignored address LSBs are intentionally not consumed.
    logic unused_ok;
    assign unused_ok = ^{cmd_addr[1:0], master.bid, master.rid, master.rlast, TIMEOUT_CYCLES[0]};

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        master.arvalid = 1'b0;
        master.awvalid = 1'b0;
        master.wvalid  = 1'b0;
        master.rready  = 1'b0;
        master.bready  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready     = rst_n;
                // Stray beats from an aborted transaction are drained here.
                master.rready = rst_n;
                master.bready = rst_n;
                if (cmd_valid) begin
                    state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                master.arvalid = 1'b1;
                if (master.arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                master.rready = 1'b1;
                if (master.rvalid) begin
                    state_d = RSP;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W retire independently; leave once both have handshaken.
                master.awvalid = !aw_done_q;
                master.wvalid  = !w_done_q;
                if ((aw_done_q || master.awready) && (w_done_q || master.wready)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                master.bready = 1'b1;
                if (master.bvalid) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                rsp_valid     = 1'b1;
                master.rready = rst_n;
                master.bready = rst_n;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
        // A real response landing in the expiry cycle takes priority over the abort.
        busy     = (state_q != IDLE) && (state_q != RSP);
        rsp_hit  = ((state_q == RD_DATA) && master.rvalid) ||
                   ((state_q == WR_RESP) && master.bvalid);
        tmo_fire = busy && !rsp_hit && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if (tmo_fire) begin
            state_d = RSP;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= {cmd_addr[AXI4_ADDRESS_WIDTH-1:2], 2'b00};
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                WR_ADDR_DATA: begin
                    if (master.awready) aw_done_q <= 1'b1;
                    if (master.wready)  w_done_q  <= 1'b1;
                end
                RD_DATA: begin
                    if (master.rvalid) begin
                        rdata_q <= master.rdata;
                        resp_q  <= master.rresp;
                    end
                end
                WR_RESP: begin
                    if (master.bvalid) begin
                        rdata_q <= '0;
                        resp_q  <= master.bresp;
                    end
                end
                default: ;
            endcase
`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
            if (tmo_fire) begin
                rdata_q <= '0;
                resp_q  <= RESP_SLVERR;
            end
`endif
        end
    end

`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if ((state_q == IDLE) && cmd_valid) begin
                tmo_cnt_q <= '0;
                tmo_q     <= 1'b0;
            end else if (busy) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
            if (tmo_fire) begin
                tmo_q <= 1'b1;
            end
        end
    end
    assign rsp_timeout = tmo_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Bench for axi4_cmd_master: table of directed commands plus randomized commands against a
// slave with programmable per-channel wait states; expected response, latency and handshake
// counts come from a small arithmetic model of the command protocol.
module tb_axi4_cmd_master;
    import axi4_cmd_master_pkg::*;

    localparam int TMO = 16;

    logic        clk_i;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    axi4_cmd_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

    axi4_cmd_master #(
        .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(32), .AXI4_ID_WIDTH(4),
        .MASTER_ID(0), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .master(axi.master)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          ar_w, r_w, aw_w, w_w, b_w;
        bit          ar_never;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        int          hold;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_tmo;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Slave configuration (written by the stimulus process only).
    int          cfg_ar_w, cfg_r_w, cfg_aw_w, cfg_w_w, cfg_b_w;
    bit          cfg_ar_never;
    logic [31:0] cfg_sdata;
    logic [1:0]  cfg_sresp;
    bit          stray_r, stray_b;

    // Slave bookkeeping (written by the slave process only).
    int  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    int  ar_wcnt, r_wcnt, aw_wcnt, w_wcnt, b_wcnt;
    bit  r_pending, b_pending, aw_got, w_got;
    logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb, cap_arid, cap_awid;
    logic        cap_wlast;
    logic [7:0]  cap_arlen, cap_awlen;
    logic [2:0]  cap_arsize, cap_awsize;
    logic [1:0]  cap_arburst, cap_awburst;
    logic [15:0] cap_arfix, cap_awfix;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: response and latency follow directly from the slave's wait states.
    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                int arw, int rw, int aww, int ww, int bw, bit never,
                                logic [31:0] sd, logic [1:0] sr, int hold);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = d; v.wstrb = s;
        v.ar_w = arw; v.r_w = rw; v.aw_w = aww; v.w_w = ww; v.b_w = bw;
        v.ar_never = never; v.sdata = sd; v.sresp = sr; v.hold = hold;
        if (never) begin
            v.exp_lat = TMO + 1; v.exp_rdata = 32'h0; v.exp_resp = RESP_SLVERR; v.exp_tmo = 1'b1;
        end else if (wr) begin
            v.exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
            v.exp_rdata = 32'h0; v.exp_resp = sr; v.exp_tmo = 1'b0;
        end else begin
            v.exp_lat = 3 + arw + rw;
            v.exp_rdata = sd; v.exp_resp = sr; v.exp_tmo = 1'b0;
        end
        return v;
    endfunction

    // Slave bookkeeping: handshakes are observed at the clock edge.
    initial begin
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_wcnt = 0; r_wcnt = 0; aw_wcnt = 0; w_wcnt = 0; b_wcnt = 0;
        r_pending = 0; b_pending = 0; aw_got = 0; w_got = 0;
        forever begin
            @(posedge clk_i);
            if (!rst_n) begin
                r_pending = 0; b_pending = 0; aw_got = 0; w_got = 0;
                ar_wcnt = 0; r_wcnt = 0; aw_wcnt = 0; w_wcnt = 0; b_wcnt = 0;
            end else begin
                if (r_pending) begin
                    if (axi.rvalid && axi.rready) begin r_pending = 0; r_hs++; end
                    else r_wcnt++;
                end
                if (b_pending) begin
                    if (axi.bvalid && axi.bready) begin b_pending = 0; b_hs++; end
                    else b_wcnt++;
                end
                if (axi.arvalid) begin
                    if (axi.arready) begin
                        ar_hs++; ar_wcnt = 0; r_pending = 1; r_wcnt = 0;
                        cap_araddr = axi.araddr; cap_arlen = axi.arlen; cap_arsize = axi.arsize;
                        cap_arburst = axi.arburst; cap_arid = axi.arid;
                        cap_arfix = {axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.arregion};
                    end else ar_wcnt++;
                end else ar_wcnt = 0;
                if (axi.awvalid) begin
                    if (axi.awready) begin
                        aw_hs++; aw_wcnt = 0; aw_got = 1;
                        cap_awaddr = axi.awaddr; cap_awlen = axi.awlen; cap_awsize = axi.awsize;
                        cap_awburst = axi.awburst; cap_awid = axi.awid;
                        cap_awfix = {axi.awlock, axi.awcache, axi.awprot, axi.awqos, axi.awregion};
                    end else aw_wcnt++;
                end else aw_wcnt = 0;
                if (axi.wvalid) begin
                    if (axi.wready) begin
                        w_hs++; w_wcnt = 0; w_got = 1;
                        cap_wdata = axi.wdata; cap_wstrb = axi.wstrb; cap_wlast = axi.wlast;
                    end else w_wcnt++;
                end else w_wcnt = 0;
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0; b_pending = 1; b_wcnt = 0;
                end
            end
        end
    end

    // Slave drive: outputs change on the falling edge only.
    initial begin
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 1; axi.rid = 0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
        forever begin
            @(negedge clk_i);
            axi.arready = axi.arvalid && !cfg_ar_never && (ar_wcnt >= cfg_ar_w);
            axi.rvalid  = (r_pending && (r_wcnt >= cfg_r_w)) || stray_r;
            axi.rdata   = stray_r ? 32'hBAD0_BAD0 : cfg_sdata;
            axi.rresp   = stray_r ? RESP_SLVERR : cfg_sresp;
            axi.awready = axi.awvalid && (aw_wcnt >= cfg_aw_w);
            axi.wready  = axi.wvalid && (w_wcnt >= cfg_w_w);
            axi.bvalid  = (b_pending && (b_wcnt >= cfg_b_w)) || stray_b;
            axi.bresp   = stray_b ? RESP_DECERR : cfg_sresp;
        end
    end

    task automatic recover();
        rst_n = 0; cmd_valid = 0; rsp_ready = 0;
        repeat (2) @(negedge clk_i);
        rst_n = 1;
        @(negedge clk_i);
    endtask

    // Present a command; returns with the accepting cycle just completed.
    task automatic issue(input vec_t v, output bit ok);
        int guard;
        cfg_ar_w = v.ar_w; cfg_r_w = v.r_w; cfg_aw_w = v.aw_w; cfg_w_w = v.w_w; cfg_b_w = v.b_w;
        cfg_ar_never = v.ar_never; cfg_sdata = v.sdata; cfg_sresp = v.sresp;
        @(negedge clk_i);
        cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk_i); guard++; end
        chk("cmd_accept", cmd_ready, 1);
        ok = cmd_ready;
        @(negedge clk_i);
        cmd_valid = 0;
        if (!ok) recover();
    endtask

    task automatic do_cmd(input vec_t v);
        bit ok;
        int lat;
        int ar0, r0, aw0, w0, b0;
        bit rd_ok, wr_ok;
        ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        issue(v, ok);
        if (!ok) return;
        chk("cmd_ready_busy", cmd_ready, 0);
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge clk_i); lat++; end
        chk("rsp_latency", lat, v.exp_lat);
        if (!rsp_valid) begin recover(); return; end
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_resp", rsp_resp, v.exp_resp);
        chk("rsp_timeout", rsp_timeout, v.exp_tmo);
        chk("rsp_valids_low", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
        chk("rsp_readies", {axi.rready, axi.bready}, 2'b11);
        rd_ok = !v.write && !v.ar_never;
        wr_ok = v.write;
        chk("n_ar", ar_hs - ar0, rd_ok ? 1 : 0);
        chk("n_r", r_hs - r0, rd_ok ? 1 : 0);
        chk("n_aw", aw_hs - aw0, wr_ok ? 1 : 0);
        chk("n_w", w_hs - w0, wr_ok ? 1 : 0);
        chk("n_b", b_hs - b0, wr_ok ? 1 : 0);
        if (rd_ok) begin
            chk("araddr", cap_araddr, {v.addr[31:2], 2'b00});
            chk("ar_attr", {cap_arid, cap_arlen, cap_arsize, cap_arburst, cap_arfix},
                {4'd0, 8'd0, 3'b010, 2'b01, 16'd0});
        end
        if (wr_ok) begin
            chk("awaddr", cap_awaddr, {v.addr[31:2], 2'b00});
            chk("wdata", cap_wdata, v.wdata);
            chk("wstrb_wlast", {cap_wstrb, cap_wlast}, {v.wstrb, 1'b1});
            chk("aw_attr", {cap_awid, cap_awlen, cap_awsize, cap_awburst, cap_awfix},
                {4'd0, 8'd0, 3'b010, 2'b01, 16'd0});
        end
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk_i);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", {rsp_rdata, rsp_resp}, {v.exp_rdata, v.exp_resp});
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1;
        @(negedge clk_i);
        rsp_ready = 0;
        chk("rsp_consumed", rsp_valid, 0);
        chk("back_to_idle", cmd_ready, 1);
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        bit   ok;
        #400000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   ok;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        rsp_ready = 0; stray_r = 0; stray_b = 0;
        cfg_ar_w = 0; cfg_r_w = 0; cfg_aw_w = 0; cfg_w_w = 0; cfg_b_w = 0;
        cfg_ar_never = 0; cfg_sdata = 0; cfg_sresp = 0;

        //            wr addr           wdata          strb  arw rw aww ww bw nv sdata          sresp        hold
        tbl.push_back(mk(1, 32'h8000_0000, 32'h0000_0005, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0,         RESP_OKAY,   0));
        tbl.push_back(mk(0, 32'h2000_0010, 32'h0,         4'h0, 0, 5, 0, 0, 0, 0, 32'hDEAD_BEEF, RESP_OKAY,   0));
        tbl.push_back(mk(1, 32'h1000_0004, 32'h1122_3344, 4'h3, 0, 0, 3, 0, 0, 0, 32'h0,         RESP_OKAY,   0));
        tbl.push_back(mk(1, 32'h1000_0008, 32'h5566_7788, 4'hC, 0, 0, 0, 3, 0, 0, 32'h0,         RESP_OKAY,   0));
        tbl.push_back(mk(0, 32'h2000_0020, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, RESP_DECERR, 10));
        tbl.push_back(mk(1, 32'h0000_0103, 32'hA5A5_5A5A, 4'h1, 0, 0, 2, 2, 2, 0, 32'h0,         RESP_SLVERR, 1));
        tbl.push_back(mk(0, 32'h0000_0007, 32'h0,         4'h0, 2, 1, 0, 0, 0, 0, 32'h0F0F_F0F0, RESP_EXOKAY, 0));

        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, rsp_valid}, 0);
        chk("rst_readies", {axi.rready, axi.bready}, 0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
        rst_n = 1;
        @(negedge clk_i);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_readies", {axi.rready, axi.bready}, 2'b11);

        foreach (tbl[i]) do_cmd(tbl[i]);

        // Stray R and B beats while idle are drained and do not disturb the next read.
        @(posedge clk_i);
        stray_r = 1; stray_b = 1;
        @(negedge clk_i);
        #1;
        chk("stray_drained", {axi.rvalid, axi.rready, axi.bvalid, axi.bready}, 4'hF);
        @(posedge clk_i);
        stray_r = 0; stray_b = 0;
        do_cmd(mk(0, 32'h4000_0040, 32'h0, 4'h0, 1, 1, 0, 0, 0, 0, 32'hCAFE_0001, RESP_OKAY, 0));

        for (int i = 0; i < 30; i++) begin
            v = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), $urandom_range(0, 4), 0, $urandom,
                   2'($urandom_range(0, 3)), $urandom_range(0, 2));
            do_cmd(v);
        end

        // Reset while waiting for B: everything drops, then a fresh command works.
        v = mk(1, 32'h5000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 40, 0, 32'h0, RESP_OKAY, 0);
        issue(v, ok);
        if (ok) begin
            @(negedge clk_i);
            chk("pre_rst_bready", {axi.bready, axi.awvalid, axi.wvalid}, 3'b100);
            rst_n = 0;
            @(negedge clk_i);
            chk("mid_rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, rsp_valid}, 0);
            chk("mid_rst_cmd_ready", cmd_ready, 0);
            rst_n = 1;
            @(negedge clk_i);
            chk("post_rst_idle", cmd_ready, 1);
        end
        do_cmd(mk(1, 32'h5000_0004, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 0, 0, 0, 32'h0, RESP_OKAY, 0));

`ifdef AXI4_CMD_MASTER_TIMEOUT_EN
        do_cmd(mk(0, 32'h3000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 32'h7777_7777, RESP_OKAY, 2));
        do_cmd(mk(0, 32'h3000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 32'h1357_9BDF, RESP_OKAY, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
